// File: rtl/demorgan_pkg.sv
// demorgan_pkg: checker state encoding, vector count and SETTLE bounds
package demorgan_pkg;
  typedef enum logic [2:0] {IDLE, DRIVE, WAIT, SAMPLE, DONE} state_t;
  localparam int NUM_VEC = 4;
  localparam int SETTLE_MIN = 1;
  localparam int SETTLE_MAX = 15;
endpackage

// File: rtl/demorgan_checker_golden.sv
// demorgan_golden: i_a,i_b -> o_exp = expected {nA,nB,nAandnB}
module demorgan_golden (
  input  logic       i_a,
  input  logic       i_b,
  output logic [2:0] o_exp
);
  assign o_exp = {~i_a, ~i_b, ~i_a & ~i_b};
endmodule

// File: rtl/demorgan_checker.sv
// demorgan_checker: sweeps {A,B} through 4 vectors, samples nA/nB/nAandnB after SETTLE cycles; reports busy/done/pass/fail_mask/err_count
module demorgan_checker
  import demorgan_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       nA,
  input  logic       nB,
  input  logic       nAandnB,
  output logic       A,
  output logic       B,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic [2:0] err_count
);
  state_t     r_state;
  logic [1:0] r_vec;
  logic [3:0] r_cnt;
  logic [2:0] w_exp;
  logic       w_mis;
  logic [2:0] w_err_nxt;
  demorgan_golden u_golden (.i_a(A), .i_b(B), .o_exp(w_exp));
  assign w_mis     = {nA, nB, nAandnB} != w_exp;
  assign w_err_nxt = err_count + {2'b0, w_mis};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_vec     <= '0;
      r_cnt     <= '0;
      A         <= 1'b0;
      B         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_mask <= '0;
      err_count <= '0;
    end else if (abort) begin
      r_state <= IDLE;
      r_vec   <= '0;
      A       <= 1'b0;
      B       <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      if (start && !busy) begin
        fail_mask <= '0;
        err_count <= '0;
      end
    end else begin
      case (r_state)
        IDLE, DONE: if (start) begin
          r_state   <= DRIVE;
          r_vec     <= '0;
          busy      <= 1'b1;
          done      <= 1'b0;
          pass      <= 1'b0;
          fail_mask <= '0;
          err_count <= '0;
        end
        DRIVE: begin
          A       <= r_vec[1];
          B       <= r_vec[0];
          r_cnt   <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'(SETTLE - 1)) r_state <= SAMPLE;
        end
        SAMPLE: begin
          if (w_mis) begin
            fail_mask[r_vec] <= 1'b1;
            err_count        <= w_err_nxt;
          end
          if (r_vec == 2'(NUM_VEC - 1)) begin
            r_state <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= w_err_nxt == 3'd0;
          end else begin
            r_vec   <= r_vec + 2'd1;
            r_state <= DRIVE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_demorgan_checker.sv
// tb_demorgan_checker: two checkers (SETTLE 1 and 3) against modelled devices, scored by a sweep-level model
module tb_demorgan_checker;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic a0, b0, busy0, done0, pass0, na0, nb0, nab0;
  logic a1, b1, busy1, done1, pass1, na1, nb1, nab1;
  logic [3:0] fm0, fm1;
  logic [2:0] ec0, ec1;
  logic [1:0] p0_1, p0_2, p1_1, p1_2;
  int mode = 0;
  int dly = 0;
  int checks = 0;
  int errors = 0;
  logic [1:0] m_ab[2];
  logic       m_act[2], m_done[2], m_pass[2];
  logic [3:0] m_full[2], m_vis[2];
  int         m_t[2];
  always #5 clk = ~clk;
  demorgan_checker #(.SETTLE(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .nA(na0), .nB(nb0), .nAandnB(nab0), .A(a0), .B(b0),
    .busy(busy0), .done(done0), .pass(pass0), .fail_mask(fm0), .err_count(ec0));
  demorgan_checker #(.SETTLE(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .nA(na1), .nB(nb1), .nAandnB(nab1), .A(a1), .B(b1),
    .busy(busy1), .done(done1), .pass(pass1), .fail_mask(fm1), .err_count(ec1));
  function automatic logic [2:0] dev(int m, logic [1:0] v);
    logic a, b;
    a = v[1];
    b = v[0];
    return m == 1 ? {~a, ~b, 1'b0} : m == 2 ? {a, ~b, ~a & ~b} :
           m == 3 ? {~a, ~b, ~a | ~b} : {~a, ~b, ~a & ~b};
  endfunction
  function automatic int st(int i);
    return i == 0 ? 1 : 3;
  endfunction
  function automatic logic [3:0] full_mask(int m, int d, int s, logic [1:0] prior);
    logic [3:0] r;
    logic [1:0] seen;
    r = '0;
    for (int v = 0; v < 4; v++) begin
      seen = d > s ? (v == 0 ? prior : 2'(v - 1)) : 2'(v);
      r[v] = dev(m, seen) != dev(0, 2'(v));
    end
    return r;
  endfunction
  function automatic logic [11:0] pk(logic a, logic b, logic bz, logic dn, logic ps,
                                     logic [3:0] fm, logic [2:0] ec);
    return {a, b, bz, dn, ps, fm, ec};
  endfunction
  function automatic logic [11:0] expv(int i);
    return pk(m_ab[i][1], m_ab[i][0], m_act[i], m_done[i], m_pass[i], m_vis[i],
              3'($countones(m_vis[i])));
  endfunction
  task automatic chk(input string nm, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (A,B,busy,done,pass,mask,err)", nm, got, exp);
    end
  endtask
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      p0_1 <= '0; p0_2 <= '0; p1_1 <= '0; p1_2 <= '0;
    end else begin
      p0_1 <= {a0, b0}; p0_2 <= p0_1; p1_1 <= {a1, b1}; p1_2 <= p1_1;
    end
  always_comb begin
    {na0, nb0, nab0} = dev(mode, dly == 0 ? {a0, b0} : p0_2);
    {na1, nb1, nab1} = dev(mode, dly == 0 ? {a1, b1} : p1_2);
  end
  initial begin
    for (int i = 0; i < 2; i++) begin
      m_ab[i] = '0; m_act[i] = 0; m_done[i] = 0; m_pass[i] = 0;
      m_full[i] = '0; m_vis[i] = '0; m_t[i] = 0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) begin
          m_ab[i] = '0; m_act[i] = 0; m_done[i] = 0; m_pass[i] = 0; m_vis[i] = '0;
        end else if (m_act[i]) begin
          if (abort) begin
            m_act[i] = 0; m_done[i] = 0; m_pass[i] = 0; m_ab[i] = '0;
          end else begin
            m_t[i]++;
            m_ab[i] = 2'((m_t[i] - 1) / (st(i) + 2));
            for (int v = 0; v < 4; v++)
              if ((v + 1) * (st(i) + 2) <= m_t[i]) m_vis[i][v] = m_full[i][v];
            if (m_t[i] == 4 * (st(i) + 2)) begin
              m_act[i] = 0; m_done[i] = 1; m_pass[i] = m_full[i] == 4'd0;
            end
          end
        end else if (abort) begin
          m_done[i] = 0; m_pass[i] = 0; m_ab[i] = '0;
          if (start) m_vis[i] = '0;
        end else if (start) begin
          m_act[i] = 1; m_t[i] = 0; m_done[i] = 0; m_pass[i] = 0; m_vis[i] = '0;
          m_full[i] = full_mask(mode, dly, st(i), m_ab[i]);
        end
      end
    end
  end
  initial forever begin
    @(negedge clk);
    chk("model0", {a0, b0, busy0, done0, pass0, fm0, ec0}, expv(0));
    chk("model1", {a1, b1, busy1, done1, pass1, fm1, ec1}, expv(1));
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic pulse_abort();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask
  task automatic sweep(input int m, input int d);
    mode = m;
    dly = d;
    pulse_start();
    cyc(21);
  endtask
  initial begin
    int k;
    #1 rst_n = 1'b0;
    #3 chk("reset_async", {a0, b0, busy0, done0, pass0, fm0, ec0}, 12'h000);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    mode = 0;
    dly = 0;
    pulse_start();
    cyc(11);
    chk("edge11", {a0, b0, busy0, done0, pass0, fm0, ec0}, pk(1, 1, 1, 0, 0, 4'b0000, 3'd0));
    cyc(1);
    chk("edge12", {a0, b0, busy0, done0, pass0, fm0, ec0}, pk(1, 1, 0, 1, 1, 4'b0000, 3'd0));
    cyc(9);
    chk("settle3_ok", {a1, b1, busy1, done1, pass1, fm1, ec1}, pk(1, 1, 0, 1, 1, 4'b0000, 3'd0));
    sweep(1, 0);
    chk("stuck_and", {a0, b0, busy0, done0, pass0, fm0, ec0}, pk(1, 1, 0, 1, 0, 4'b0001, 3'd1));
    sweep(2, 0);
    chk("na_noninv", {a0, b0, busy0, done0, pass0, fm0, ec0}, pk(1, 1, 0, 1, 0, 4'b1111, 3'd4));
    sweep(0, 2);
    chk("delay_s1", {a0, b0, busy0, done0, pass0, fm0, ec0}, pk(1, 1, 0, 1, 0, 4'b1111, 3'd4));
    chk("delay_s3", {a1, b1, busy1, done1, pass1, fm1, ec1}, pk(1, 1, 0, 1, 1, 4'b0000, 3'd0));
    mode = 2;
    dly = 0;
    pulse_start();
    cyc(4);
    pulse_start();
    cyc(1);
    chk("restart_ign", {a0, b0, busy0, done0, pass0, fm0, ec0}, pk(0, 1, 1, 0, 0, 4'b0011, 3'd2));
    cyc(1);
    pulse_abort();
    chk("abort_vec2", {a0, b0, busy0, done0, pass0, fm0, ec0}, pk(0, 0, 0, 0, 0, 4'b0011, 3'd2));
    cyc(2);
    pulse_start();
    cyc(7);
    #2 rst_n = 1'b0;
    #1 chk("reset_wait0", {a0, b0, busy0, done0, pass0, fm0, ec0}, 12'h000);
    chk("reset_wait1", {a1, b1, busy1, done1, pass1, fm1, ec1}, 12'h000);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1);
    for (int it = 0; it < 40; it++) begin
      mode = int'($urandom_range(0, 3));
      dly = int'($urandom_range(0, 1)) * 2;
      k = int'($urandom_range(0, 4));
      if (k == 4) begin
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        cyc(2);
        continue;
      end
      pulse_start();
      if (k == 3) begin
        cyc(int'($urandom_range(1, 18)));
        pulse_abort();
        cyc(2);
      end else if (k == 2) begin
        cyc(int'($urandom_range(1, 18)));
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1);
      end else begin
        cyc(int'($urandom_range(1, 9)));
        pulse_start();
        cyc(22);
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/demorgan_checker.md
DEMORGAN_CHECKER -- requirements
Module: demorgan_checker

Interface
REQ-001 Parameter: SETTLE, default 1, number of clock cycles the DUT outputs settle before sampling; legal range 1..15.
REQ-002 Ports (clock and reset first):
- clk  input  1  single system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request one full truth-table sweep.
- abort  input  1  cancel the sweep in progress.
- nA  input  1  DUT output, expected ~A.
- nB  input  1  DUT output, expected ~B.
- nAandnB  input  1  DUT output, expected ~A & ~B.
- A  output  1  registered stimulus to the DUT.
- B  output  1  registered stimulus to the DUT.
- busy  output  1  sweep in progress.
- done  output  1  sweep completed; results valid.
- pass  output  1  done and no mismatches.
- fail_mask  output  4  bit v set = vector v ({A,B}=v) mismatched.
- err_count  output  3  number of mismatching vectors, 0..4.

Function
REQ-003 States: IDLE, DRIVE, WAIT, SAMPLE, DONE; state register one-hot or binary, choice free.
REQ-004 IDLE/DONE + start=1 -> DRIVE; vec=0; fail_mask, err_count, done, pass cleared on the same edge.
REQ-005 DRIVE: on exit edge A<=vec[1], B<=vec[0]; settle counter <=0; -> WAIT.
REQ-006 WAIT: counter increments each cycle; -> SAMPLE on the edge where counter==SETTLE-1.
REQ-007 SAMPLE: compare {nA,nB,nAandnB} against {~A,~B,~A&~B} from the registered A,B; on any bit mismatch set fail_mask[vec], increment err_count.
REQ-008 SAMPLE, vec<3 -> vec+1, DRIVE; vec==3 -> DONE; vec never wraps.
REQ-009 Per vector: exactly SETTLE+2 cycles; done first high after edge E0+4*(SETTLE+2), E0 = edge sampling start (12 edges for SETTLE=1).
REQ-010 DONE: done=1, pass=(err_count==0), busy=0; A,B hold last vector (1,1); results held until next start or reset.
REQ-011 busy=1 exactly in DRIVE, WAIT, SAMPLE.
REQ-012 start while busy: ignored; no restart, no result change.
REQ-013 abort while busy: -> IDLE next edge; A=B=0, done=0, pass=0; fail_mask/err_count retain partial values.
REQ-014 abort and start in the same cycle in IDLE/DONE: abort wins; stay/go IDLE, results cleared as for start, done=0.
REQ-015 abort outside busy with start=0: DONE -> IDLE, done and pass cleared.
REQ-016 err_count saturates at 4 by construction; no overflow path.

Reset
REQ-017 rst_n low: immediately, independent of clk, state=IDLE, vec=0, counter=0, A=0, B=0, busy=0, done=0, pass=0, fail_mask=0000, err_count=000.
REQ-018 Reset mid-sweep aborts with no partial results; first start after rst_n deasserts behaves per REQ-004.

Structure
REQ-019 Shared package demorgan_pkg holds the state encoding, NUM_VEC=4, and the SETTLE legal range bounds.
REQ-020 One sub-module demorgan_golden: combinational A,B -> expected {nA,nB,nAandnB}; checker instantiates it once.

Verification
REQ-021 Correct DUT, SETTLE=1, start pulse -> done after 12 edges, pass=1, fail_mask=0000, err_count=0.
REQ-022 nAandnB stuck at 0 -> fail_mask=0001, err_count=1, pass=0.
REQ-023 nA wired to A (non-inverted) -> fail_mask=1111, err_count=4, pass=0.
REQ-024 SETTLE=3, DUT with 2-cycle output delay -> pass=1; SETTLE=1, same DUT -> pass=0.
REQ-025 abort during vec 2 -> IDLE next edge, A=B=0, done=0; start ignored mid-sweep when repeated during vec 1.
REQ-026 rst_n low during WAIT, asynchronous to clk -> all outputs at reset values before the next clk edge.
